// File: rtl/vga_ball_shadow_regs.sv
// Avalon-MM shadow register front end for the ball display core.
// CPU writes land in shadow registers and are committed together on the first vsync-low cycle.
module vga_ball_shadow_regs #(
  parameter logic [9:0] RESET_X      = 10'd30,
  parameter logic [9:0] RESET_Y      = 10'd30,
  parameter logic [7:0] RESET_RADIUS = 8'd16,
  parameter logic [7:0] RESET_BG_R   = 8'h00,
  parameter logic [7:0] RESET_BG_G   = 8'h99,
  parameter logic [7:0] RESET_BG_B   = 8'h60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       vga_vs,
  output logic       irq,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] radius,
  output logic [7:0] bg_r,
  output logic [7:0] bg_g,
  output logic [7:0] bg_b
);

  localparam logic [2:0] ADDR_RADIUS = 3'd0;
  localparam logic [2:0] ADDR_BG_R   = 3'd1;
  localparam logic [2:0] ADDR_BG_G   = 3'd2;
  localparam logic [2:0] ADDR_BG_B   = 3'd3;
  localparam logic [2:0] ADDR_X_LO   = 3'd4;
  localparam logic [2:0] ADDR_X_HI   = 3'd5;
  localparam logic [2:0] ADDR_Y_LO   = 3'd6;
  localparam logic [2:0] ADDR_Y_HI   = 3'd7;

  logic [9:0] sh_x;
  logic [9:0] sh_y;
  logic [7:0] sh_radius;
  logic [7:0] sh_bg_r;
  logic [7:0] sh_bg_g;
  logic [7:0] sh_bg_b;
  logic [4:0] x_lo_stage;
  logic [4:0] y_lo_stage;
  logic       commit_pending;
  logic       irq_pending;
  logic [7:0] frame_count;
  logic       vs_q;

  logic       wr_en;
  logic       rd_en;
  logic       frame_start;
  logic       sets_pending;
  logic [7:0] rd_mux;

  always_comb begin
    wr_en        = chipselect & write;
    rd_en        = chipselect & read;
    frame_start  = vs_q & ~vga_vs;
    // Low-half staging writes only prime the coordinate; they never arm a commit.
    sets_pending = wr_en & (address != ADDR_X_LO) & (address != ADDR_Y_LO);
  end

  // NOTE: every register here is a flop with an async reset; all updates use <=
  // so same-edge reads see pre-edge values (shadow -> committed copy relies on it).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_x       <= RESET_X;
      sh_y       <= RESET_Y;
      sh_radius  <= RESET_RADIUS;
      sh_bg_r    <= RESET_BG_R;
      sh_bg_g    <= RESET_BG_G;
      sh_bg_b    <= RESET_BG_B;
      x_lo_stage <= '0;
      y_lo_stage <= '0;
    end else if (wr_en) begin
      unique case (address)
        ADDR_RADIUS: sh_radius  <= writedata;
        ADDR_BG_R:   sh_bg_r    <= writedata;
        ADDR_BG_G:   sh_bg_g    <= writedata;
        ADDR_BG_B:   sh_bg_b    <= writedata;
        ADDR_X_LO:   x_lo_stage <= writedata[4:0];
        ADDR_X_HI:   sh_x       <= {writedata[4:0], x_lo_stage};
        ADDR_Y_LO:   y_lo_stage <= writedata[4:0];
        ADDR_Y_HI:   sh_y       <= {writedata[4:0], y_lo_stage};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ball_x <= RESET_X;
      ball_y <= RESET_Y;
      radius <= RESET_RADIUS;
      bg_r   <= RESET_BG_R;
      bg_g   <= RESET_BG_G;
      bg_b   <= RESET_BG_B;
    end else if (frame_start && commit_pending) begin
      ball_x <= sh_x;
      ball_y <= sh_y;
      radius <= sh_radius;
      bg_r   <= sh_bg_r;
      bg_g   <= sh_bg_g;
      bg_b   <= sh_bg_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q           <= 1'b1;
      commit_pending <= 1'b0;
      irq_pending    <= 1'b0;
      frame_count    <= '0;
    end else begin
      vs_q <= vga_vs;
      // A write landing on the frame edge re-arms the commit for the next frame.
      if (sets_pending)     commit_pending <= 1'b1;
      else if (frame_start) commit_pending <= 1'b0;
      // The frame edge beats a status read that would clear the interrupt.
      if (frame_start)
        irq_pending <= 1'b1;
      else if (rd_en && address == 3'd0)
        irq_pending <= 1'b0;
      if (frame_start) frame_count <= frame_count + 8'd1;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (address)
      3'd0:    rd_mux = {irq_pending, commit_pending, 6'b0};
      3'd1:    rd_mux = frame_count;
      3'd2:    rd_mux = ball_x[9:2];
      3'd3:    rd_mux = ball_y[9:2];
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

  assign irq = irq_pending;

endmodule

// File: tb/tb_vga_ball_shadow_regs.sv
// Self-checking bench for vga_ball_shadow_regs: directed bus/vsync scenarios with a
// read-data scoreboard queue; expected values derived by hand from the register map.
module tb_vga_ball_shadow_regs;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       chipselect;
  logic       write;
  logic       read;
  logic [2:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       vga_vs;
  logic       irq;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] radius;
  logic [7:0] bg_r;
  logic [7:0] bg_g;
  logic [7:0] bg_b;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_frames = 0;
  logic [7:0] rd_q[$];

  vga_ball_shadow_regs dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .vga_vs     (vga_vs),
    .irq        (irq),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .radius     (radius),
    .bg_r       (bg_r),
    .bg_g       (bg_g),
    .bg_b       (bg_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One bus cycle with optional write, read and vsync fall in the same clock.
  task automatic bus(input logic do_wr, input logic do_rd, input logic [2:0] addr,
                     input logic [7:0] wd, input logic fall, input logic [7:0] rd_exp,
                     input string tag);
    logic [7:0] exp;
    chipselect = 1'b1;
    write      = do_wr;
    read       = do_rd;
    address    = addr;
    writedata  = wd;
    if (fall) vga_vs = 1'b0;
    if (do_rd) rd_q.push_back(rd_exp);
    @(posedge clk); #1;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    vga_vs     = 1'b1;
    if (fall) exp_frames = (exp_frames + 1) % 256;
    if (do_rd) begin
      exp = rd_q.pop_front();
      check(tag, {24'b0, readdata}, {24'b0, exp});
    end
    if (fall) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] wd);
    bus(1'b1, 1'b0, addr, wd, 1'b0, 8'h00, "wr");
  endtask

  task automatic rd(input logic [2:0] addr, input logic [7:0] exp, input string tag);
    bus(1'b0, 1'b1, addr, 8'h00, 1'b0, exp, tag);
  endtask

  task automatic frame();
    bus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'h00, "frame");
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = 3'd0;
    writedata  = 8'h00;
    vga_vs     = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset values
    check("rst_x",  ball_x, 10'd30);
    check("rst_y",  ball_y, 10'd30);
    check("rst_rad", radius, 8'd16);
    check("rst_bg", {bg_r, bg_g, bg_b}, 24'h009960);
    check("rst_irq", irq, 1'b0);
    check("rst_rdata", readdata, 8'h00);
    rd(3'd0, 8'h00, "rst_status");

    // Split x write; no commit before frame
    wr(3'd4, 8'h0A);
    wr(3'd5, 8'h03);
    check("x_before_frame", ball_x, 10'd30);
    frame();
    check("x_commit", ball_x, 10'h06A);
    check("x_irq", irq, 1'b1);
    check("x_rad_same", radius, 8'd16);
    rd(3'd1, 8'(exp_frames), "fc_1");
    rd(3'd2, 8'h1A, "rd_x_hi");
    @(posedge clk); #1;
    check("rdata_hold", readdata, 8'h1A);
    rd(3'd3, 8'h07, "rd_y_hi");
    rd(3'd5, 8'h00, "rd_unused");

    // Low-half write alone does not arm a commit
    wr(3'd6, 8'h1F);
    frame();
    check("y_lo_only", ball_y, 10'd30);
    rd(3'd0, 8'h80, "status_irq");
    rd(3'd0, 8'h00, "status_cleared");
    check("irq_cleared", irq, 1'b0);

    // High write reuses retained stage; upper data bits ignored
    wr(3'd7, 8'hE1);
    rd(3'd0, 8'h40, "status_pending");
    frame();
    check("y_retained", ball_y, 10'd63);
    rd(3'd0, 8'h80, "status_after_y");

    // Write on the frame edge: old shadow commits, new write waits a frame
    wr(3'd1, 8'h11);
    bus(1'b1, 1'b0, 3'd0, 8'h40, 1'b1, 8'h00, "wr_on_edge");
    check("edge_rad_old", radius, 8'd16);
    check("edge_bg_r", bg_r, 8'h11);
    rd(3'd0, 8'hC0, "status_edge");
    frame();
    check("edge_rad_next", radius, 8'd64);

    // Status read on the frame edge: returns old irq, frame wins the clear
    rd(3'd0, 8'h80, "status_pre");
    check("irq_low_pre", irq, 1'b0);
    bus(1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, "rd_edge_old0");
    check("irq_set_edge", irq, 1'b1);
    bus(1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 8'h80, "rd_edge_old1");
    check("irq_stays", irq, 1'b1);
    rd(3'd1, 8'd7, "fc_7");

    // Frame counter wrap after 256 frames total
    while (exp_frames != 255) frame();
    rd(3'd1, 8'd255, "fc_255");
    frame();
    rd(3'd1, 8'd0, "fc_wrap");

    // Async reset mid-frame discards the pending shadow write
    wr(3'd1, 8'hFF);
    check("irq_before_rst", irq, 1'b1);
    reset_n = 1'b0;
    #2;
    check("async_bg_r", bg_r, 8'h00);
    check("async_rad", radius, 8'd16);
    check("async_irq", irq, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(3'd0, 8'h00, "status_after_rst");
    frame();
    check("no_commit_bg_r", bg_r, 8'h00);
    check("no_commit_y", ball_y, 10'd30);
    rd(3'd1, 8'd1, "fc_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
